// File: rtl/inv_round.sv
// Two-stage AES inverse-cipher round: InvShiftRows+InvSubBytes, then AddRoundKey
// and (unless FINAL) InvMixColumns. All 386 state bits also form a serial scan chain.
module inv_round #(
  parameter bit FINAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scan_input,
  output logic         scan_output,
  input  logic         scan_ck_en,
  input  logic         scan_enable,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  input  logic [127:0] key,
  output logic         out_valid,
  output logic [127:0] state_out
);

  localparam int unsigned BW = 8;
  localparam int unsigned NB = 16;
  localparam int unsigned SW = BW * NB;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] bb;
    p  = '0;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = xtime(x);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, x);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, x);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, x);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, x);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, x);
    return gmul(x127, x127);
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  logic         v1_q, v1_d;
  logic [SW-1:0] t_q, t_d;
  logic [SW-1:0] k_q, k_d;
  logic         v2_q, v2_d;
  logic [SW-1:0] so_q, so_d;

  logic [SW-1:0] t_fn;
  logic [SW-1:0] u;
  logic [SW-1:0] mix;
  logic [SW-1:0] res;

  // Output byte (r, c) takes input byte (r, (c - r) mod 4).
  for (genvar g = 0; g < NB; g++) begin : g_s1
    localparam int unsigned R   = g % 4;
    localparam int unsigned C   = g / 4;
    localparam int unsigned SRC = 4 * ((C + 4 - R) % 4) + R;
    assign t_fn[SW-1-BW*g -: BW] = inv_sbox(state_in[SW-1-BW*SRC -: BW]);
  end

  assign u = t_q ^ k_q;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = u[SW-1-BW*(4*c)   -: BW];
    assign a1 = u[SW-1-BW*(4*c+1) -: BW];
    assign a2 = u[SW-1-BW*(4*c+2) -: BW];
    assign a3 = u[SW-1-BW*(4*c+3) -: BW];
    assign mix[SW-1-BW*(4*c)   -: BW] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mix[SW-1-BW*(4*c+1) -: BW] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mix[SW-1-BW*(4*c+2) -: BW] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mix[SW-1-BW*(4*c+3) -: BW] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign res = FINAL ? u : mix;

  // Scan shift order: scan_input -> v1 -> t -> k -> v2 -> state_out -> scan_output.
  always_comb begin
    v1_d = v1_q;
    t_d  = t_q;
    k_d  = k_q;
    v2_d = v2_q;
    so_d = so_q;
    if (scan_enable) begin
      if (scan_ck_en) begin
        v1_d = scan_input;
        t_d  = {t_q[SW-2:0], v1_q};
        k_d  = {k_q[SW-2:0], t_q[SW-1]};
        v2_d = k_q[SW-1];
        so_d = {so_q[SW-2:0], v2_q};
      end
    end else begin
      v1_d = in_valid;
      t_d  = t_fn;
      k_d  = key;
      v2_d = v1_q;
      so_d = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      t_q  <= '0;
      k_q  <= '0;
      v2_q <= 1'b0;
      so_q <= '0;
    end else begin
      v1_q <= v1_d;
      t_q  <= t_d;
      k_q  <= k_d;
      v2_q <= v2_d;
      so_q <= so_d;
    end
  end

  assign out_valid   = v2_q;
  assign state_out   = so_q;
  assign scan_output = so_q[SW-1];

endmodule

// File: tb/tb_inv_round.sv
// Scoreboard bench for inv_round: one FINAL=0 and one FINAL=1 instance share stimulus;
// a table-driven reference model feeds per-instance expectation queues.
module tb_inv_round;

  localparam int unsigned SW = 128;
  localparam int unsigned CW = 386;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_input;
  logic          scan_ck_en;
  logic          scan_enable;
  logic          in_valid;
  logic [SW-1:0] state_in;
  logic [SW-1:0] key;
  logic          so0, so1, ov0, ov1;
  logic [SW-1:0] st0, st1;

  always #5 clk = ~clk;

  inv_round #(.FINAL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .scan_input(scan_input), .scan_output(so0),
    .scan_ck_en(scan_ck_en), .scan_enable(scan_enable), .in_valid(in_valid),
    .state_in(state_in), .key(key), .out_valid(ov0), .state_out(st0)
  );

  inv_round #(.FINAL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .scan_input(scan_input), .scan_output(so1),
    .scan_ck_en(scan_ck_en), .scan_enable(scan_enable), .in_valid(in_valid),
    .state_in(state_in), .key(key), .out_valid(ov1), .state_out(st1)
  );

  int unsigned   n_chk = 0;
  int unsigned   n_pass = 0;
  logic [7:0]    isb [256];
  logic [SW-1:0] q0 [$];
  logic [SW-1:0] q1 [$];
  logic [SW-1:0] last0, last1, cur_e0, cur_e1;
  logic [1:0]    hist;
  logic          mon_en;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Polynomial product then reduction by 0x11b.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 8'd1) != 8'd0) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 15'd1) != 15'd0) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Inverse S-box obtained by inverting the forward S-box (brute-force inverse + affine).
  task automatic build_isb();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, inv, s;
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[3:0], inv[7:4]} ^ {inv[4:0], inv[7:5]} ^ {inv[5:0], inv[7:6]}
          ^ {inv[6:0], inv[7]} ^ 8'h63;
      isb[s] = xb;
    end
  endtask

  function automatic logic [7:0] gb(input logic [SW-1:0] s, input int k);
    return 8'(s >> (8 * (15 - k)));
  endfunction

  function automatic logic [SW-1:0] ref_t(input logic [SW-1:0] s);
    logic [SW-1:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      int r, c, src;
      r   = k % 4;
      c   = k / 4;
      src = 4 * ((c - r + 4) % 4) + r;
      o   = {o[SW-9:0], isb[gb(s, src)]};
    end
    return o;
  endfunction

  function automatic logic [SW-1:0] ref_mix(input logic [SW-1:0] u);
    logic [SW-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(u, 4*c); a1 = gb(u, 4*c+1); a2 = gb(u, 4*c+2); a3 = gb(u, 4*c+3);
      o = {o[SW-33:0],
           gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
           gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
           gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
           gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [SW-1:0] ref_round(input logic [SW-1:0] s, input logic [SW-1:0] k,
                                              input bit fin);
    return fin ? (ref_t(s) ^ k) : ref_mix(ref_t(s) ^ k);
  endfunction

  function automatic logic [SW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic monitor(input bit pop);
    check("out_valid0", CW'(ov0), CW'(hist[1]));
    check("out_valid1", CW'(ov1), CW'(hist[1]));
    if (hist[1]) begin
      if (!pop) begin
        check("hold_state0", CW'(st0), CW'(last0));
        check("hold_state1", CW'(st1), CW'(last1));
      end else if (q0.size() == 0 || q1.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underrun: got empty queue expected a pending result");
      end else begin
        last0 = q0.pop_front();
        last1 = q1.pop_front();
        check("state_out0", CW'(st0), CW'(last0));
        check("state_out1", CW'(st1), CW'(last1));
      end
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic was_rst, func, hold, push;
    logic [SW-1:0] e0, e1;
    was_rst = rst;
    func    = !rst && !scan_enable;
    hold    = !rst && scan_enable && !scan_ck_en;
    push    = func && in_valid;
    e0      = cur_e0;
    e1      = cur_e1;
    @(posedge clk);
    #1;
    if (was_rst) begin
      hist  = 2'b00;
      last0 = '0;
      last1 = '0;
      q0.delete();
      q1.delete();
      check("rst_out_valid0", CW'(ov0), '0);
      check("rst_state_out0", CW'(st0), '0);
      check("rst_scan_out0", CW'(so0), '0);
      check("rst_out_valid1", CW'(ov1), '0);
      check("rst_state_out1", CW'(st1), '0);
      check("rst_scan_out1", CW'(so1), '0);
    end else if (func) begin
      if (push) begin
        q0.push_back(e0);
        q1.push_back(e1);
      end
      hist = {hist[0], push};
      if (mon_en) monitor(1'b1);
    end else if (hold && mon_en) begin
      monitor(1'b0);
    end
  endtask

  task automatic drive(input logic [SW-1:0] s, input logic [SW-1:0] k,
                       input logic [SW-1:0] e0, input logic [SW-1:0] e1);
    state_in   = s;
    key        = k;
    in_valid   = 1'b1;
    cur_e0     = e0;
    cur_e1     = e1;
    scan_ck_en = 1'($urandom);
    tick();
  endtask

  task automatic drive_rand();
    logic [SW-1:0] s, k;
    s = rnd128();
    k = rnd128();
    drive(s, k, ref_round(s, k, 1'b0), ref_round(s, k, 1'b1));
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    state_in   = rnd128();
    key        = rnd128();
    scan_ck_en = 1'($urandom);
    tick();
  endtask

  // Shift the whole chain once, feeding `fed` MSB first and capturing scan_output.
  task automatic shift_all(input logic [CW-1:0] fed, output logic [CW-1:0] cap0,
                           output logic [CW-1:0] cap1);
    logic [CW-1:0] f;
    f           = fed;
    cap0        = '0;
    cap1        = '0;
    scan_enable = 1'b1;
    scan_ck_en  = 1'b1;
    for (int j = 0; j < int'(CW); j++) begin
      cap0       = {cap0[CW-2:0], so0};
      cap1       = {cap1[CW-2:0], so1};
      scan_input = f[CW-1];
      f          = f << 1;
      tick();
    end
  endtask

  initial begin
    logic [SW-1:0] s1, k1, s2, k2, s;
    logic [CW-1:0] fed, cap0, cap1, exp0, exp1;
    logic [SW-1:0] hold0, hold1;

    build_isb();
    rst = 1'b1; scan_input = 1'b0; scan_ck_en = 1'b0; scan_enable = 1'b0;
    in_valid = 1'b0; state_in = '0; key = '0; cur_e0 = '0; cur_e1 = '0;
    hist = 2'b00; mon_en = 1'b1; last0 = '0; last1 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    drive('0, '0, {16{8'h52}}, {16{8'h52}});
    idle();
    drive('0, {16{8'hff}}, {16{8'had}}, {16{8'had}});
    s = {8'h00, 8'h63, 112'h0};
    drive(s, '0, ref_round(s, '0, 1'b0), {{5{8'h52}}, 8'h00, {10{8'h52}}});
    repeat (3) idle();

    // Random streaming, then single-cycle gaps.
    repeat (100) drive_rand();
    repeat (20) begin
      drive_rand();
      idle();
    end
    repeat (3) idle();

    // Freeze mid-flight with scan_ck_en low, then resume.
    repeat (3) drive_rand();
    scan_enable = 1'b1;
    scan_ck_en  = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom);
      state_in = rnd128();
      tick();
    end
    scan_enable = 1'b0;
    repeat (3) drive_rand();
    repeat (3) idle();

    // Reset while streaming.
    repeat (4) drive_rand();
    rst = 1'b1;
    drive_rand();
    rst = 1'b0;
    repeat (5) drive_rand();
    repeat (3) idle();

    // Scan round-trip from a known pipeline state.
    s1 = rnd128(); k1 = rnd128(); s2 = rnd128(); k2 = rnd128();
    drive(s1, k1, ref_round(s1, k1, 1'b0), ref_round(s1, k1, 1'b1));
    drive(s2, k2, ref_round(s2, k2, 1'b0), ref_round(s2, k2, 1'b1));
    mon_en = 1'b0;
    in_valid = 1'b0;
    exp0 = {ref_round(s1, k1, 1'b0), 1'b1, k2, ref_t(s2), 1'b1};
    exp1 = {ref_round(s1, k1, 1'b1), 1'b1, k2, ref_t(s2), 1'b1};
    fed = '0;
    for (int j = 0; j < int'(CW); j++) fed = {fed[CW-2:0], 1'($urandom)};
    shift_all(fed, cap0, cap1);
    check("scan_unload0", cap0, exp0);
    check("scan_unload1", cap1, exp1);
    check("scan_load_state0", CW'(st0), CW'(fed[CW-1 -: SW]));
    check("scan_load_valid0", CW'(ov0), CW'(fed[CW-1-SW]));
    check("scan_load_state1", CW'(st1), CW'(fed[CW-1 -: SW]));
    hold0 = fed[CW-1 -: SW];
    hold1 = fed[CW-1 -: SW];
    scan_ck_en = 1'b0;
    repeat (3) begin
      scan_input = 1'($urandom);
      tick();
      check("scan_hold0", CW'(st0), CW'(hold0));
      check("scan_hold1", CW'(st1), CW'(hold1));
      check("scan_hold_so0", CW'(so0), CW'(fed[CW-1]));
    end
    shift_all('0, cap0, cap1);
    check("scan_return0", cap0, fed);
    check("scan_return1", cap1, fed);

    // Reset in the middle of a shift clears the whole chain.
    scan_ck_en = 1'b1;
    repeat (10) begin
      scan_input = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shift_all('0, cap0, cap1);
    check("scan_after_rst0", cap0, '0);
    check("scan_after_rst1", cap1, '0);

    // Functional mode resumes cleanly.
    scan_enable = 1'b0;
    mon_en      = 1'b1;
    repeat (10) drive_rand();
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_round.md
# inv_round

Pipelined AES inverse-cipher round with an embedded scan chain. It performs the decryption counterpart of the encrypt-side round blocks: InvShiftRows and InvSubBytes, then AddRoundKey, then InvMixColumns. A parameter selects the final inverse round, which omits InvMixColumns. Several instances are chained by the decryption datapath, and their scan ports are daisy-chained into the design-wide scan path used for state snapshot and restore.

## Interface
- FINAL, 0, 1 = final inverse round (no InvMixColumns); 0 = full inverse round
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- scan_input  in  1  serial scan data in
- scan_output  out  1  serial scan data out; equals state_out[127]
- scan_ck_en  in  1  scan shift strobe; honoured only while scan_enable=1
- scan_enable  in  1  1 = scan mode (functional update frozen); 0 = functional mode
- in_valid  in  1  state_in/key qualify this cycle
- state_in  in  128  round input; byte 0 = [127:120]; FIPS-197 column-major
- key  in  128  round key, sampled together with state_in
- out_valid  out  1  state_out holds a new result
- state_out  out  128  round output

## Operation
- Registers:
  - v1: stage-1 valid.
  - t_r[127:0]: InvSubBytes(InvShiftRows(state_in)).
  - k_r[127:0]: key registered alongside t_r.
  - v2: drives out_valid.
  - state_out.
- InvShiftRows: output byte (row r, col c) = input byte (r, (c−r) mod 4). Byte index = 4c+r.
- InvSubBytes: FIPS-197 inverse S-box on each of the 16 bytes. Implemented as combinational logic or a case ROM, with no extra register.
- Stage 2:
  - u = t_r ^ k_r.
  - FINAL=0: state_out = InvMixColumns(u). Each column is multiplied by {0e,0b,0d,09} circulant in GF(2^8), polynomial 0x11b.
  - FINAL=1: state_out = u.
- Functional mode (scan_enable=0), every cycle:
  - v1<=in_valid; t_r, k_r load.
  - v2<=v1; state_out loads.
  - Data registers load regardless of valid; valid bits only qualify them.
- Scan mode (scan_enable=1):
  - scan_ck_en=0: all registers hold.
  - scan_ck_en=1: the 386-bit chain shifts one position, in this order:
    - v1<=scan_input
    - t_r<={t_r[126:0],v1}
    - k_r<={k_r[126:0],t_r[127]}
    - v2<=k_r[127]
    - state_out<={state_out[126:0],v2}
- Priority: rst > scan_enable > functional.

## Timing
- Reset: all registers clear to 0, so out_valid=0, state_out=0, scan_output=0. The first edge after rst deasserts behaves normally.
- Latency: in_valid with data at edge N gives out_valid=1 with result after edge N+2.
- Throughput: 1 block/cycle with no stalls. There is no backpressure; the consumer must sample while out_valid=1.
- Back-to-back inputs produce back-to-back outputs in order. An in_valid gap gives an out_valid gap exactly 2 cycles later.
- Entering scan mode mid-flight freezes both stages. Returning to functional mode resumes from the frozen (or shifted-in) contents; no in-flight result is lost while scan_ck_en=0.
- Full unload takes 386 scan_ck_en cycles. The first bit out is the current state_out[127]; bit 386 is the old v1.
- rst asserted mid-shift aborts the shift; the chain reads all-zero afterwards.
- scan_ck_en is ignored while scan_enable=0.

## Test plan
- FINAL=1, state_in=0, key=0, in_valid pulse -> 2 cycles later out_valid=1, state_out=5252…52 (16 bytes). With key=all-ff -> adad…ad.
- FINAL=0, state_in=0, key=0 -> state_out=5252…52 (InvMixColumns of a uniform 0x52 column returns 0x52).
- FINAL=1, key=0, state_in byte 1 ([119:112]) = 0x63, all other bytes 0x00 -> state_out byte 5 ([87:80]) = 0x00, all other bytes 0x52. This checks the InvShiftRows direction.
- Random streaming: in_valid high for 100 cycles with random data, then 1-cycle gaps -> every output matches the reference model in order; out_valid mirrors in_valid delayed by 2.
- Scan round-trip:
  - Load a known state, assert scan_enable, shift 386 cycles while feeding a pseudo-random sequence and capturing scan_output.
  - Captured bits equal the prior register contents in chain order.
  - A second 386-shift returns the fed sequence.
  - With scan_ck_en=0 the registers hold.
- Reset priority: assert rst during functional streaming and again during a scan shift -> next cycle out_valid=0, state_out=0, scan_output=0.
